// File: rtl/nv_nvdla_pdp_wdma_pkg.sv
// Shared constants and helpers for the PDP write-DMA flop FIFO.
package nv_nvdla_pdp_wdma_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 3;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic int ptrInc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_wdma_flopram.sv
// DEPTH x WIDTH flop storage with one write port and one async read port.
// Read address DEPTH returns the write data, used as the bypass leg.
module nv_nvdla_pdp_wdma_flopram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (wa == AW'(i))) begin
        mem[i] <= di;
      end
    end
  end

  // Any address outside the storage falls through to di.
  always_comb begin
    dout = di;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra == AW'(i)) begin
        dout = mem[i];
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_pdp_wdma_flop_fifo.sv
// Parametrised flop-RAM FIFO between the PDP output formatter and WDMA packer.
// Optional empty-FIFO bypass enabled by NV_NVDLA_PDP_WDMA_FIFO_BYPASS_EN.
module nv_nvdla_pdp_wdma_flop_fifo
  import nv_nvdla_pdp_wdma_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = countWidth(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic [31:0]      pwrbus_ram_pd,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [CW-1:0]    wr_count
);

  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    rdPtr_q, rdPtr_d;
  logic             push, pop;
  logic [CW-1:0]    ramRa;
  logic [WIDTH-1:0] ramDout;
  logic             unusedPwrbus;

  assign unusedPwrbus = ^pwrbus_ram_pd;

  assign wr_prdy  = (count_q != CW'(DEPTH)) && nvdla_core_rstn;
  assign wr_count = count_q;

`ifdef NV_NVDLA_PDP_WDMA_FIFO_BYPASS_EN
  logic bypass;

  // An empty FIFO hands wr_pd straight through; a taken bypass touches no state.
  assign bypass  = (count_q == '0) && wr_pvld;
  assign rd_pvld = (count_q != '0) || bypass;
  assign ramRa   = bypass ? CW'(DEPTH) : rdPtr_q;
  assign push    = wr_pvld && wr_prdy && !(bypass && rd_prdy);
  assign pop     = rd_pvld && rd_prdy && !bypass;
`else
  assign rd_pvld = (count_q != '0);
  assign ramRa   = rdPtr_q;
  assign push    = wr_pvld && wr_prdy;
  assign pop     = rd_pvld && rd_prdy;
`endif

  assign rd_pd = rd_pvld ? ramDout : '0;

  nv_nvdla_pdp_wdma_flopram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (CW)
  ) uRam (
    .clk  (nvdla_core_clk),
    .we   (push),
    .wa   (wrPtr_q),
    .di   (wr_pd),
    .ra   (ramRa),
    .dout (ramDout)
  );

  always_comb begin
    count_d = count_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) begin
      wrPtr_d = CW'(ptrInc(int'(wrPtr_q), DEPTH));
    end
    if (pop) begin
      rdPtr_d = CW'(ptrInc(int'(rdPtr_q), DEPTH));
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset drops pointers and count; storage keeps stale words that are now unreachable.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      count_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      count_q <= count_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_wdma_flop_fifo.sv
// Scoreboard bench for nv_nvdla_pdp_wdma_flop_fifo (DEPTH=3, WIDTH=64).
module tb_nv_nvdla_pdp_wdma_flop_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 3;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic [31:0]      pwrbus;
  logic             wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [WIDTH-1:0] wr_pd, rd_pd;
  logic [CW-1:0]    wr_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb[$];
  int               modelCount;
  logic             prevHeld;
  logic [WIDTH-1:0] prevData;

  logic             obsPrdy, obsRvld, expPrdy, expRvld, popped;
  logic [WIDTH-1:0] obsRpd, expRpd;
  logic [CW-1:0]    obsCount;

  always #5 clk = ~clk;

  nv_nvdla_pdp_wdma_flop_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .pwrbus_ram_pd   (pwrbus),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .wr_count        (wr_count)
  );

  // Drive one cycle, sample combinational outputs, update the scoreboard model.
  task automatic driveCycle(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
    logic byp;
    wr_pvld = wv;
    wr_pd   = wd;
    rd_prdy = rr;
    #1;
    obsPrdy = wr_prdy;
    obsRvld = rd_pvld;
    obsRpd  = rd_pd;
    if (prevHeld && wv) begin
      checks++;
      if (wd !== prevData) begin
        errors++;
        $display("[TB] FAIL hold_data: got %0h required %0h", wd, prevData);
      end
    end
    expPrdy = rstn && (modelCount != DEPTH);
    byp = 1'b0;
`ifdef NV_NVDLA_PDP_WDMA_FIFO_BYPASS_EN
    byp = (modelCount == 0) && wv;
`endif
    expRvld  = (modelCount != 0) || byp;
    expRpd   = byp ? wd : ((modelCount != 0) ? sb[0] : '0);
    popped   = 1'b0;
    prevHeld = wv && !expPrdy;
    prevData = wd;
    if (!rstn) begin
      sb.delete();
      modelCount = 0;
      prevHeld   = 1'b0;
    end else if (byp && rr) begin
      popped = 1'b1;
    end else begin
      if (expRvld && rr) begin
        void'(sb.pop_front());
        modelCount--;
        popped = 1'b1;
      end
      if (wv && expPrdy) begin
        sb.push_back(wd);
        modelCount++;
      end
    end
    @(posedge clk);
    #1;
    obsCount = wr_count;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    driveCycle(1'b0, '0, 1'b0);
    checks++;
    if (obsPrdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_prdy_low: got %0b required 0", obsPrdy); end
    checks++;
    if (obsCount !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d required 0", obsCount); end
    rstn = 1'b1;
    driveCycle(1'b0, '0, 1'b0);
    checks++;
    if (obsPrdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_prdy_high: got %0b required 1", obsPrdy); end
    checks++;
    if (obsRvld !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvld: got %0b required 0", obsRvld); end
    checks++;
    if (obsRpd !== '0) begin errors++; $display("[TB] FAIL reset_rpd: got %0h required 0", obsRpd); end
    checks++;
    if (obsCount !== '0) begin errors++; $display("[TB] FAIL idle_count: got %0d required 0", obsCount); end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] vals [3];
    vals = '{64'hA, 64'hB, 64'hC};
    for (int i = 0; i < 3; i++) begin
      driveCycle(1'b1, vals[i], 1'b0);
      checks++;
      if (obsPrdy !== expPrdy) begin errors++; $display("[TB] FAIL fill_prdy: got %0b required %0b", obsPrdy, expPrdy); end
      checks++;
      if (obsCount !== CW'(modelCount)) begin errors++; $display("[TB] FAIL fill_count: got %0d required %0d", obsCount, modelCount); end
    end
    checks++;
    if (obsCount !== 2'd3) begin errors++; $display("[TB] FAIL full_count: got %0d required 3", obsCount); end
    for (int i = 0; i < 2; i++) begin
      driveCycle(1'b1, 64'hD, 1'b0);
      checks++;
      if (obsPrdy !== 1'b0) begin errors++; $display("[TB] FAIL full_refuse: got %0b required 0", obsPrdy); end
      checks++;
      if (obsCount !== 2'd3) begin errors++; $display("[TB] FAIL full_hold_count: got %0d required 3", obsCount); end
    end
    for (int i = 0; i < 3; i++) begin
      driveCycle(1'b0, '0, 1'b1);
      checks++;
      if (obsRvld !== expRvld) begin errors++; $display("[TB] FAIL drain_rvld: got %0b required %0b", obsRvld, expRvld); end
      checks++;
      if (obsRpd !== expRpd) begin errors++; $display("[TB] FAIL drain_data: got %0h required %0h", obsRpd, expRpd); end
    end
    driveCycle(1'b0, '0, 1'b0);
    checks++;
    if (obsRvld !== 1'b0) begin errors++; $display("[TB] FAIL drained_rvld: got %0b required 0", obsRvld); end
    checks++;
    if (obsRpd !== '0) begin errors++; $display("[TB] FAIL drained_rpd: got %0h required 0", obsRpd); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 11; i++) begin
      driveCycle(i <= 10, (i <= 10) ? WIDTH'(i) : '0, 1'b1);
      checks++;
      if (obsRvld !== expRvld) begin errors++; $display("[TB] FAIL wrap_rvld: got %0b required %0b", obsRvld, expRvld); end
      if (popped) begin
        checks++;
        if (obsRpd !== expRpd) begin errors++; $display("[TB] FAIL wrap_data: got %0h required %0h", obsRpd, expRpd); end
      end
      checks++;
      if (obsCount !== CW'(modelCount)) begin errors++; $display("[TB] FAIL wrap_count: got %0d required %0d", obsCount, modelCount); end
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 3; i++) driveCycle(1'b1, 64'h100 + WIDTH'(i), 1'b0);
    driveCycle(1'b1, 64'h777, 1'b1);
    checks++;
    if (obsPrdy !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_prdy: got %0b required 0", obsPrdy); end
    checks++;
    if (obsRpd !== expRpd) begin errors++; $display("[TB] FAIL fullpop_data: got %0h required %0h", obsRpd, expRpd); end
    checks++;
    if (obsCount !== 2'd2) begin errors++; $display("[TB] FAIL fullpop_count: got %0d required 2", obsCount); end
    driveCycle(1'b0, '0, 1'b0);
    checks++;
    if (obsPrdy !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_prdy_next: got %0b required 1", obsPrdy); end
    for (int i = 0; i < 2; i++) begin
      driveCycle(1'b0, '0, 1'b1);
      checks++;
      if (obsRpd !== expRpd) begin errors++; $display("[TB] FAIL fullpop_drain: got %0h required %0h", obsRpd, expRpd); end
    end
  endtask

`ifdef NV_NVDLA_PDP_WDMA_FIFO_BYPASS_EN
  task automatic test_bypass();
    driveCycle(1'b1, 64'h55, 1'b1);
    checks++;
    if (obsRvld !== 1'b1) begin errors++; $display("[TB] FAIL bypass_rvld: got %0b required 1", obsRvld); end
    checks++;
    if (obsRpd !== 64'h55) begin errors++; $display("[TB] FAIL bypass_data: got %0h required 55", obsRpd); end
    checks++;
    if (obsCount !== 2'd0) begin errors++; $display("[TB] FAIL bypass_count: got %0d required 0", obsCount); end
    driveCycle(1'b1, 64'h66, 1'b0);
    checks++;
    if (obsRpd !== 64'h66) begin errors++; $display("[TB] FAIL bypass_stall_data: got %0h required 66", obsRpd); end
    checks++;
    if (obsCount !== 2'd1) begin errors++; $display("[TB] FAIL bypass_stall_count: got %0d required 1", obsCount); end
    driveCycle(1'b0, '0, 1'b1);
    checks++;
    if (obsRpd !== expRpd) begin errors++; $display("[TB] FAIL bypass_drain: got %0h required %0h", obsRpd, expRpd); end
  endtask
`endif

  task automatic test_reset_mid();
    driveCycle(1'b1, 64'hE1, 1'b0);
    driveCycle(1'b1, 64'hE2, 1'b0);
    checks++;
    if (obsCount !== 2'd2) begin errors++; $display("[TB] FAIL mid_pre_count: got %0d required 2", obsCount); end
    rstn = 1'b0;
    driveCycle(1'b1, 64'hE3, 1'b1);
    rstn = 1'b1;
    checks++;
    if (obsCount !== 2'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d required 0", obsCount); end
    driveCycle(1'b1, 64'h99, 1'b0);
    checks++;
    if (obsRvld !== expRvld) begin errors++; $display("[TB] FAIL mid_rvld: got %0b required %0b", obsRvld, expRvld); end
    driveCycle(1'b0, '0, 1'b1);
    checks++;
    if (obsRpd !== 64'h99) begin errors++; $display("[TB] FAIL mid_readback: got %0h required 99", obsRpd); end
    checks++;
    if (obsCount !== 2'd0) begin errors++; $display("[TB] FAIL mid_end_count: got %0d required 0", obsCount); end
  endtask

  initial begin
    rstn       = 1'b0;
    pwrbus     = '0;
    wr_pvld    = 1'b0;
    wr_pd      = '0;
    rd_prdy    = 1'b0;
    modelCount = 0;
    prevHeld   = 1'b0;
    prevData   = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
`ifdef NV_NVDLA_PDP_WDMA_FIFO_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_pdp_wdma_flop_fifo.md
# nv_nvdla_pdp_wdma_flop_fifo

Parametrised flop-RAM FIFO for the PDP write-DMA data path. It generalises the fixed 3x64 flop RAM into a complete FIFO: configurable width and depth (including non-power-of-two depths), valid/ready handshakes on both sides, an occupancy count, and an optional empty-FIFO bypass. It sits between the PDP output formatter (write side) and the WDMA request packer (read side).

## Interface
- WIDTH, 64, data width in bits
- DEPTH, 3, number of entries; must be ≥ 2, any integer
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset; **synchronous, active-low, one clock**
- pwrbus_ram_pd  in  32  RAM power-down bus; no function in a flop implementation
- wr_pvld  in  1  write data valid
- wr_prdy  out  1  write ready
- wr_pd  in  WIDTH  write data
- rd_pvld  out  1  read data valid
- rd_prdy  in  1  read ready
- rd_pd  out  WIDTH  read data
- wr_count  out  CW  registered occupancy, 0..DEPTH

## Operation
- A push happens when wr_pvld && wr_prdy. A pop happens when rd_pvld && rd_prdy.
- Data may not change while valid is high and ready is low. This is the producer's obligation; the bench flags violations.
- wr_prdy = (count != DEPTH) && nvdla_core_rstn.
  - When full, push is refused even if a pop occurs in the same cycle. There is no full-pass-through.
- Write pointer and read pointer are each in 0..DEPTH-1.
  - Each pointer increments on its event.
  - From DEPTH-1, a pointer wraps to 0. There is no power-of-two assumption.
- Count update rule: count_next = count + push − pop.
  - A simultaneous push and pop leaves the count unchanged.
- Entry wr_ptr is written on push with wr_pd. Entries are never reset.
- rd_pd = ram[rd_ptr] when rd_pvld, else all zeros (deterministic output).
- Reset (rstn low at a clock edge):
  - wr_ptr, rd_ptr and count go to 0.
  - Any in-flight handshake in that cycle is discarded.
  - RAM contents are retained but unreachable.

## Timing
- Reset values:
  - rd_pvld = 0, rd_pd = 0, wr_count = 0.
  - wr_prdy = 0 while rstn is low, and 1 from the first cycle after rstn goes high.
- Latency without bypass: data pushed at edge N is visible on rd_pd with rd_pvld = 1 after edge N, i.e. one cycle.
- wr_count reflects all pushes and pops at the preceding edge.
- rd_pvld = (count != 0) in the non-bypass build. It is a pure function of flops.
- Empty with a simultaneous push: no pop is possible that cycle. The entry becomes readable next cycle.
- Full with a simultaneous pop: the pop completes, and wr_prdy rises the next cycle.

## Configuration
- Macro: NV_NVDLA_PDP_WDMA_FIFO_BYPASS_EN.
- **Defined:** when count == 0 and wr_pvld, the FIFO bypasses the RAM.
  - rd_pvld = 1 and rd_pd = wr_pd combinationally, with zero latency.
  - If rd_prdy is also high, the word is consumed directly. The RAM is not written, and pointers and count are unchanged.
  - If rd_prdy is low, a normal push occurs.
  - rd_pvld = (count != 0) || (count == 0 && wr_pvld).
- **Undefined:** no combinational path from wr_* to rd_*. Behaviour is exactly as in Operation and Timing.

## Structure
- Shared package nv_nvdla_pdp_wdma_pkg holds:
  - the pointer-increment-with-wrap function;
  - the count-width helper;
  - default WIDTH/DEPTH constants.
- Sub-module nv_nvdla_pdp_wdma_flopram:
  - DEPTH×WIDTH flop storage, one write port (we, wa, di) and one async read port (ra, dout);
  - read address DEPTH returns di. This mux leg is used by the bypass build.
- The FIFO top holds the pointers, count, handshake logic and the bypass mux.

## Test plan
- Reset then idle (DEPTH=3, WIDTH=64): after rstn rises → wr_prdy=1, rd_pvld=0, rd_pd=0, wr_count=0.
- Fill then drain:
  - Push 0xA, 0xB, 0xC with rd_prdy=0 → wr_count=3, wr_prdy=0.
  - A fourth push attempt is held and refused.
  - Drain → 0xA, 0xB, 0xC in order, then rd_pvld=0.
- Wrap at non-power-of-two depth:
  - Run 10 continuous push/pop pairs with values 1..10 at DEPTH=3 → output order 1..10.
  - wr_count is steady at 1 after the first push.
  - Pointers sequence 0,1,2,0,…
- Full with simultaneous pop: at count=3, assert wr_pvld and rd_prdy → the pop completes, the push is refused, count=2, and wr_prdy=1 next cycle.
- Bypass (macro defined):
  - Empty, wr_pvld=1 with 0x55, rd_prdy=1 → rd_pvld=1 and rd_pd=0x55 in the same cycle, wr_count stays 0.
  - Repeat with rd_prdy=0 → wr_count=1 next cycle.
- Reset mid-operation: count=2, then drive rstn low for one edge with push and pop asserted → count=0, rd_pvld=0, and the next push is read back correctly.
